// File: rtl/meas_tx_pkg.sv
// Shared command codes and FSM state encoding for the measurement transmit sequencer.
package meas_tx_pkg;

    localparam logic [7:0] CMD_START = 8'h00;
    localparam logic [7:0] CMD_CHSEL = 8'h10;
    localparam logic [7:0] CMD_CONT  = 8'h20;
    localparam logic [7:0] CMD_STOP  = 8'h21;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        WAIT_SUM,
        SEND,
        WAIT_HI,
        WAIT_LO,
        REARM
    } state_t;

    // Channel-select commands carry the channel number in the low nibble.
    function automatic logic is_chsel(input logic [7:0] code);
        return code[7:4] == CMD_CHSEL[7:4];
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Saturating wait-phase timer; count holds the number of cycles elapsed since the last clear.
module seq_timer #(
    parameter int TIMEOUT = 2000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count;

    // The clearing cycle itself counts as the first elapsed cycle of the new state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= CW'(1);
        end else if (count != LIMIT) begin
            count <= count + CW'(1);
        end
    end

    assign expired = !clear && (count == LIMIT);

endmodule

// File: rtl/meas_tx_sequencer.sv
// Command-driven sequencer: decodes UART commands, starts measurements and streams the
// result bytes to the UART transmitter, with per-phase timeout and continuous mode.
module meas_tx_sequencer
    import meas_tx_pkg::*;
#(
    parameter  int NUM_BYTES = 3,
    parameter  int NUM_CH    = 4,
    parameter  int TIMEOUT   = 2000,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sum_ready,
    input  logic             tx_busy,
    input  logic             rx_ready,
    input  logic [7:0]       rx_data,
    output logic             sum_en,
    output logic [CH_W-1:0]  ch_sel,
    output logic             tx_send,
    output logic [IDX_W-1:0] send_sel,
    output logic             cont_mode,
    output logic             err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
    localparam logic [4:0]       NUM_CH_V = 5'(NUM_CH);

    state_t           state;
    state_t           prev_state;
    logic [7:0]       cmd;
    logic [7:0]       pend_data;
    logic             pend_valid;
    logic [IDX_W-1:0] idx;
    logic             timer_clear;
    logic             timer_expired;

    assign timer_clear = (state != prev_state);

    seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (timer_clear),
        .expired (timer_expired)
    );

    // sum_en stays high from measurement start until the frame ends, so a REARM
    // shows up as a single low cycle between back-to-back frames.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            prev_state <= IDLE;
            cmd        <= '0;
            pend_data  <= '0;
            pend_valid <= 1'b0;
            idx        <= '0;
            sum_en     <= 1'b0;
            tx_send    <= 1'b0;
            send_sel   <= '0;
            ch_sel     <= '0;
            cont_mode  <= 1'b0;
            err        <= 1'b0;
        end else begin
            prev_state <= state;
            err        <= 1'b0;
            tx_send    <= 1'b0;

            // Commands arriving while busy are parked; the newest one wins.
            if (rx_ready && (state inside {DECODE, SEND, WAIT_HI, WAIT_LO, REARM})) begin
                pend_valid <= 1'b1;
                pend_data  <= rx_data;
            end

            case (state)
                IDLE, WAIT_SUM: begin
                    if (pend_valid) begin
                        cmd        <= pend_data;
                        pend_valid <= rx_ready;
                        pend_data  <= rx_data;
                        sum_en     <= 1'b0;
                        state      <= DECODE;
                    end else if (rx_ready) begin
                        cmd    <= rx_data;
                        sum_en <= 1'b0;
                        state  <= DECODE;
                    end else if (state == WAIT_SUM && sum_ready) begin
                        idx      <= '0;
                        send_sel <= '0;
                        tx_send  <= 1'b1;
                        state    <= SEND;
                    end
                end
                DECODE: begin
                    if (cmd == CMD_START) begin
                        sum_en <= 1'b1;
                        state  <= WAIT_SUM;
                    end else if (cmd == CMD_CONT) begin
                        cont_mode <= 1'b1;
                        sum_en    <= 1'b1;
                        state     <= WAIT_SUM;
                    end else if (cmd == CMD_STOP) begin
                        cont_mode <= 1'b0;
                        state     <= IDLE;
                    end else if (is_chsel(cmd) && ({1'b0, cmd[3:0]} < NUM_CH_V)) begin
                        ch_sel <= CH_W'(cmd[3:0]);
                        state  <= IDLE;
                    end else begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                SEND: begin
                    state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (tx_busy) begin
                        state <= WAIT_LO;
                    end else if (timer_expired) begin
                        err       <= 1'b1;
                        cont_mode <= 1'b0;
                        sum_en    <= 1'b0;
                        send_sel  <= '0;
                        idx       <= '0;
                        state     <= IDLE;
                    end
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        if (idx != LAST_IDX) begin
                            idx      <= idx + IDX_W'(1);
                            send_sel <= idx + IDX_W'(1);
                            tx_send  <= 1'b1;
                            state    <= SEND;
                        end else begin
                            idx      <= '0;
                            send_sel <= '0;
                            sum_en   <= 1'b0;
                            state    <= cont_mode ? REARM : IDLE;
                        end
                    end else if (timer_expired) begin
                        err       <= 1'b1;
                        cont_mode <= 1'b0;
                        sum_en    <= 1'b0;
                        send_sel  <= '0;
                        idx       <= '0;
                        state     <= IDLE;
                    end
                end
                REARM: begin
                    sum_en <= 1'b1;
                    state  <= WAIT_SUM;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/meas_tx_sequencer.md
MEAS_TX_SEQUENCER -- requirements
Module: meas_tx_sequencer

Interface
REQ-001 Parameter NUM_BYTES, default 3, number of result bytes sent per measurement (range 1..16).
REQ-002 Parameter NUM_CH, default 4, number of selectable sensor channels (range 1..16).
REQ-003 Parameter TIMEOUT, default 2000, clk cycles allowed per tx_busy wait phase before abort.
REQ-004 Port clk  input  1  single block clock; all state changes on rising edge.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port sum_ready  input  1  measurement result valid; sampled only in WAIT_SUM.
REQ-007 Port tx_busy  input  1  UART transmitter busy.
REQ-008 Port rx_ready  input  1  one-cycle pulse; rx_data valid.
REQ-009 Port rx_data  input  8  received command byte.
REQ-010 Port sum_en  output  1  enables the measurement adder.
REQ-011 Port ch_sel  output  max(1,clog2(NUM_CH))  currently selected channel.
REQ-012 Port tx_send  output  1  one-cycle request to transmit the selected byte.
REQ-013 Port send_sel  output  max(1,clog2(NUM_BYTES))  index of result byte to transmit.
REQ-014 Port cont_mode  output  1  continuous mode active.
REQ-015 Port err  output  1  one-cycle pulse on timeout abort or invalid command.

Function
REQ-016 The FSM SHALL have states IDLE, DECODE, WAIT_SUM, SEND, WAIT_HI, WAIT_LO, REARM.
REQ-017 IDLE: rx_ready -> DECODE (rx_data registered); all outputs except ch_sel/cont_mode low.
REQ-018 DECODE, one cycle: 0x00 -> WAIT_SUM; 0x20 -> set cont_mode, WAIT_SUM; 0x21 -> clear cont_mode, IDLE; 0x1c with c<NUM_CH -> ch_sel=c, IDLE; any other byte, or 0x1c with c>=NUM_CH -> err pulse, IDLE, ch_sel unchanged.
REQ-019 WAIT_SUM: sum_en=1; rx_ready -> DECODE (priority over sum_ready when simultaneous); else sum_ready -> SEND with byte index 0.
REQ-020 SEND: tx_send=1 for exactly one cycle, send_sel=index, -> WAIT_HI.
REQ-021 WAIT_HI: send_sel held; tx_busy=1 -> WAIT_LO; timer reaching TIMEOUT -> err, IDLE.
REQ-022 WAIT_LO: send_sel held; tx_busy=0 -> if index<NUM_BYTES-1 then index+1, SEND; else REARM if cont_mode, IDLE otherwise; timer reaching TIMEOUT -> err, IDLE.
REQ-023 Timeout abort SHALL also clear cont_mode.
REQ-024 REARM: sum_en=0 for one cycle, -> WAIT_SUM (new measurement starts).
REQ-025 rx_ready during SEND/WAIT_HI/WAIT_LO/REARM SHALL latch rx_data into a one-entry pending buffer (later byte overwrites); pending command SHALL be decoded on next entry to IDLE or WAIT_SUM, before other transitions.
REQ-026 Timer SHALL clear on every state change, count otherwise, saturate at TIMEOUT.
REQ-027 NUM_BYTES=1 SHALL skip the index increment path; send_sel constant 0.

Reset
REQ-028 reset_n low SHALL asynchronously force IDLE, sum_en=0, tx_send=0, send_sel=0, ch_sel=0, cont_mode=0, err=0, timer=0, index=0, pending cleared.
REQ-029 Reset mid-transmission SHALL abandon the frame; no tx_send after release until a new command.

Structure
REQ-030 Package meas_tx_pkg SHALL hold command codes (CMD_START 0x00, CMD_CHSEL 0x10, CMD_CONT 0x20, CMD_STOP 0x21) and the state enumeration.
REQ-031 Sub-module seq_timer (parameter TIMEOUT, inputs clear, output expired) SHALL implement REQ-026.

Verification
REQ-032 Reset, rx 0x00, sum_ready, tx_busy 10-cycle pulses after each send -> 3 tx_send pulses with send_sel 0,1,2, then IDLE, err=0.
REQ-033 rx 0x12 then 0x00 -> ch_sel=2; rx 0x17 (NUM_CH=4) -> err pulse, ch_sel stays 2.
REQ-034 rx 0x20, two sum_ready cycles -> two 3-byte frames, sum_en low one cycle between; rx 0x21 mid-frame -> frame completes, then IDLE.
REQ-035 tx_busy held low after SEND -> err at TIMEOUT cycles, IDLE, cont_mode=0.
REQ-036 rx_ready and sum_ready same cycle in WAIT_SUM -> DECODE taken, no tx_send.
REQ-037 reset_n asserted in WAIT_LO -> all outputs zero immediately, no further tx_send.
